// File: rtl/hack_pkg.sv
// Shared types and sizing for the Hack CPU datapath.
// Holds the PC address type and return-stack defaults.
package hack_pkg;

  localparam int PC_W          = 16;
  localparam int RAS_DEPTH_DEF = 8;

  typedef logic [15:0] addr_t;

endpackage

// File: rtl/Add16.sv
// 16-bit adder shared with the PC incrementer.
// Carry out is discarded, so the sum wraps mod 2^16.
module Add16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] out
);

  assign out = a + b;

endmodule

// File: rtl/ret_addr_stack.sv
// Return-address stack driving the PC load/in pair.
// Define RAS_OVERFLOW_WRAP_EN for circular overwrite on full.
import hack_pkg::*;

module ret_addr_stack #(
  parameter int DEPTH = RAS_DEPTH_DEF,
  parameter int AW    = PC_W
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       call,
  input  logic                       ret,
  input  logic [AW-1:0]              target,
  input  logic [AW-1:0]              pc_cur,
  input  logic                       clr_err,
  output logic                       pc_load,
  output logic [AW-1:0]              pc_addr,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty,
  output logic                       full,
  output logic                       ovf,
  output logic                       unf,
  output logic                       conflict
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [PW-1:0] P1 = PW'(1);
  localparam logic [CW-1:0] C1 = CW'(1);
  localparam logic [CW-1:0] CD = CW'(DEPTH);

  logic [AW-1:0] mem [DEPTH];
  logic [PW-1:0] sp;
  logic [AW-1:0] ret_pc;
  logic [AW-1:0] top;
  logic          do_call;
  logic          do_ret;
  logic          push;
  logic          pop;
  logic          ovf_ev;
  logic          unf_ev;
  logic          cfl_ev;

  Add16 u_inc (
    .a   (pc_cur),
    .b   (16'd1),
    .out (ret_pc)
  );

  assign empty = (count == '0);
  assign full  = (count == CD);

  // Decode strobes into stack actions and error events.
  always_comb begin
    do_call = call & ~ret & ~reset;
    do_ret  = ret & ~call & ~reset;
    cfl_ev  = call & ret & ~reset;
    unf_ev  = do_ret & empty;
    ovf_ev  = do_call & full;
    pop     = do_ret & ~empty;
`ifdef RAS_OVERFLOW_WRAP_EN
    push    = do_call;
`else
    push    = do_call & ~full;
`endif
  end

  // Combinational PC redirect: target on call, top entry otherwise.
  always_comb begin
    top     = empty ? '0 : mem[sp - P1];
    pc_load = do_call | pop;
    pc_addr = top;
    if (reset)
      pc_addr = '0;
    else if (do_call)
      pc_addr = target;
  end

  // Entry array; contents survive reset.
  always_ff @(posedge clk) begin
    if (push)
      mem[sp] <= ret_pc;
  end

  // Pointer and occupancy; a wrapping push on full keeps count.
  always_ff @(posedge clk) begin
    if (reset) begin
      sp    <= '0;
      count <= '0;
    end else if (push) begin
      sp <= sp + P1;
      if (!full)
        count <= count + C1;
    end else if (pop) begin
      sp    <= sp - P1;
      count <= count - C1;
    end
  end

  // Sticky error flags; a new event beats clr_err.
  always_ff @(posedge clk) begin
    if (reset) begin
      ovf      <= 1'b0;
      unf      <= 1'b0;
      conflict <= 1'b0;
    end else begin
      ovf      <= (ovf & ~clr_err) | ovf_ev;
      unf      <= (unf & ~clr_err) | unf_ev;
      conflict <= (conflict & ~clr_err) | cfl_ev;
    end
  end

endmodule

// File: doc/ret_addr_stack.md
# ret_addr_stack

Return-address stack that sits beside the 16-bit program counter and drives its `load`/`in` pair. On a call it pushes the PC's current value + 1 and redirects the PC to the call target. On a return it pops the saved address back into the PC. The block is the write side of the PC's load interface; the CPU control decode supplies `call`/`ret` strobes.

## Interface
- `DEPTH`, 8: number of stack entries; power of two, ≥ 2.
- `AW`, 16: address width; matches the PC width.

Ports:
- `clk`  in  1  clock, rising edge
- `reset`  in  1  reset; synchronous, active-high
- `call`  in  1  call strobe, one cycle per call
- `ret`  in  1  return strobe, one cycle per return
- `target`  in  AW  call destination, valid with `call`
- `pc_cur`  in  AW  current PC output value
- `clr_err`  in  1  clears the sticky error flags
- `pc_load`  out  1  drives PC `load`
- `pc_addr`  out  AW  drives PC `in`
- `count`  out  $clog2(DEPTH+1)  number of valid entries
- `empty`  out  1  `count == 0`
- `full`  out  1  `count == DEPTH`
- `ovf`  out  1  sticky overflow flag
- `unf`  out  1  sticky underflow flag
- `conflict`  out  1  sticky flag for `call` and `ret` in the same cycle

## Operation
- **State:** `DEPTH` × `AW` entry array, top pointer `sp`, `count`, three sticky flags.
- **Call** (`call`=1, `ret`=0):
  - Push `pc_cur + 1`, mod 2^AW, so 0xFFFF pushes 0x0000.
  - Same cycle: `pc_load`=1, `pc_addr`=`target`.
  - `count` increments at the next edge.
- **Return** (`ret`=1, `call`=0, not empty):
  - Same cycle: `pc_load`=1, `pc_addr`=top entry.
  - Pop at the next edge; `count` decrements.
- **Return on empty:**
  - `pc_load`=0; `pc_addr` undefined (don't-care).
  - `unf` set at the next edge; no other state change.
- **Call on full:** see Configuration.
  - The jump is always performed (`pc_load`=1, `pc_addr`=`target`).
  - `ovf` set at the next edge.
- **Call and ret together:**
  - `pc_load`=0; no push or pop.
  - `conflict` set at the next edge.
- **Idle:** `pc_load`=0, `pc_addr`=top entry (0 when empty).
- **Sticky flags:**
  - Cleared by `reset` or `clr_err`.
  - If `clr_err` coincides with a new error, the set wins.
- **Reset:** has priority over everything.
  - While `reset`=1, `pc_load`=0 and `call`/`ret` are ignored.
  - Entry contents are not cleared.

## Timing
- `pc_load` and `pc_addr` are combinational from `call`/`ret`/`target`/top entry.
  - The PC captures them at the same edge the stack updates.
  - Zero-cycle redirect.
- `count`, `empty`, `full` and the flags are registered; they update one edge after the strobe.
- Back-to-back operations are legal every cycle.
  - A `ret` in the cycle after a `call` returns the just-pushed address.
- Reset values:
  - `count`=0, `empty`=1, `full`=0.
  - `ovf`=`unf`=`conflict`=0.
  - `pc_load`=0, `pc_addr`=0.

## Configuration
- `RAS_OVERFLOW_WRAP_EN`, **defined:** circular buffer.
  - A call on full overwrites the oldest entry.
  - `sp` advances mod `DEPTH`; `count` stays at `DEPTH`.
  - The last `DEPTH` returns stay correct.
- `RAS_OVERFLOW_WRAP_EN`, **undefined:** a call on full drops the push.
  - Stack contents and `count` are unchanged.
  - The jump still occurs.
- `ovf` is set in both builds.

## Structure
- Shared package `hack_pkg` holds:
  - `addr_t` (logic [15:0]);
  - `PC_W` = 16;
  - `RAS_DEPTH_DEF` = 8.
- One sub-module: the existing `Add16` instance computes `pc_cur + 1` (b = 16'd1), the same as the PC's incrementer.
- Storage is a register array, not a RAM macro, because the top entry is read combinationally.

## Test plan
- **Single call/return:** reset; `pc_cur`=0x0010, `call`, `target`=0x0200 → `pc_load`=1, `pc_addr`=0x0200, `count`=1. Then `ret` → `pc_addr`=0x0011, `count`=0, `empty`=1.
- **Nesting:** calls from `pc_cur` 0x0001, 0x0002, 0x0003, then three returns → `pc_addr` sequence 0x0004, 0x0003, 0x0002; `empty` afterwards.
- **Wrap-around:** `pc_cur`=0xFFFF, `call` → `ret` yields `pc_addr`=0x0000.
- **Overflow:** with `DEPTH`=8, nine calls from `pc_cur` 0x0100..0x0108.
  - Both builds: `ovf`=1, `full`=1.
  - Defined: eight returns yield 0x0109..0x0102.
  - Undefined: eight returns yield 0x0108..0x0101.
- **Underflow and conflict:**
  - `ret` on empty → `pc_load`=0, `unf`=1.
  - `call`+`ret` same cycle → `pc_load`=0, `conflict`=1, `count` unchanged.
  - `clr_err` → all flags 0.
- **Reset mid-operation:** two pushes, then `reset` asserted with `call`=1 → `pc_load`=0, `count`=0, `empty`=1, flags 0.
